// File: rtl/fir_decim_avg.sv
// Block averager and 2-entry output queue behind the 3rd-order FIR, with a sticky drop flag.
// Optional round-half-up averaging is enabled by defining FIR_DECIM_ROUND_EN.
module fir_decim_avg #(
    parameter int IN_W       = 10,
    parameter int LOG2_DECIM = 2
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic [IN_W-1:0] Y_in,
    input  logic            Y_valid,
    output logic [IN_W-1:0] Avg_out,
    output logic            Avg_valid,
    input  logic            Avg_ready,
    output logic            Ovf
);

    localparam int ACC_W = IN_W + LOG2_DECIM;
    localparam int CNT_W = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
    localparam int DECIM = 1 << LOG2_DECIM;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
`ifdef FIR_DECIM_ROUND_EN
    localparam logic [ACC_W-1:0] RND = ACC_W'(DECIM / 2);
`endif

    typedef enum logic [1:0] {
        Q_EMPTY = 2'b00,
        Q_ONE   = 2'b01,
        Q_FULL  = 2'b10
    } q_state_t;

    logic [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic [ACC_W-1:0] sum_s;
    logic [IN_W-1:0]  result_s;
    logic             push_s;
    logic             pop_s;
    q_state_t         state_r;
    q_state_t         next_state_s;
    logic [IN_W-1:0]  head_r;
    logic [IN_W-1:0]  tail_r;
    logic [IN_W-1:0]  head_nxt_s;
    logic [IN_W-1:0]  tail_nxt_s;
    logic             drop_s;
    logic             valid_r;
    logic             ovf_r;

    assign push_s   = Y_valid && (cnt_r == CNT_LAST);
    assign pop_s    = (state_r != Q_EMPTY) && Avg_ready;
    assign result_s = sum_s[ACC_W-1:LOG2_DECIM];

    // Running block sum; the rounding term only enters on the closing sample so acc never sees it.
    always_comb begin
        sum_s = acc_r + ACC_W'(Y_in);
`ifdef FIR_DECIM_ROUND_EN
        if (push_s) begin
            sum_s = sum_s + RND;
        end else begin
            sum_s = sum_s;
        end
`endif
    end

    // Accumulator and sample counter; both hold across Y_valid gaps.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            acc_r <= {ACC_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
        end else if (Y_valid) begin
            if (push_s) begin
                acc_r <= {ACC_W{1'b0}};
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                acc_r <= sum_s;
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
        end
    end

    // Queue occupancy state register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_r <= Q_EMPTY;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Queue occupancy next state; a simultaneous push and pop leaves occupancy unchanged.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            Q_EMPTY: begin
                if (push_s) next_state_s = Q_ONE;
                else        next_state_s = Q_EMPTY;
            end
            Q_ONE: begin
                if (push_s && !pop_s)      next_state_s = Q_FULL;
                else if (pop_s && !push_s) next_state_s = Q_EMPTY;
                else                       next_state_s = Q_ONE;
            end
            Q_FULL: begin
                if (pop_s && !push_s) next_state_s = Q_ONE;
                else                  next_state_s = Q_FULL;
            end
            default: next_state_s = Q_EMPTY;
        endcase
    end

    // Queue data movement and drop detection.
    always_comb begin
        head_nxt_s = head_r;
        tail_nxt_s = tail_r;
        drop_s     = 1'b0;
        case (state_r)
            Q_EMPTY: begin
                if (push_s) head_nxt_s = result_s;
                else        head_nxt_s = head_r;
            end
            Q_ONE: begin
                if (push_s && pop_s) head_nxt_s = result_s;
                else if (push_s)     tail_nxt_s = result_s;
                else                 head_nxt_s = head_r;
            end
            Q_FULL: begin
                if (pop_s) begin
                    head_nxt_s = tail_r;
                    if (push_s) tail_nxt_s = result_s;
                    else        tail_nxt_s = tail_r;
                end else if (push_s) begin
                    drop_s = 1'b1;
                end else begin
                    drop_s = 1'b0;
                end
            end
            default: begin
                head_nxt_s = head_r;
                tail_nxt_s = tail_r;
                drop_s     = 1'b0;
            end
        endcase
    end

    // Registered queue storage and outputs; head keeps its last value once the queue empties.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            head_r  <= {IN_W{1'b0}};
            tail_r  <= {IN_W{1'b0}};
            valid_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
            valid_r <= (next_state_s != Q_EMPTY);
            ovf_r   <= ovf_r | drop_s;
        end
    end

    assign Avg_out   = head_r;
    assign Avg_valid = valid_r;
    assign Ovf       = ovf_r;

endmodule

// File: tb/tb_fir_decim_avg.sv
// Self-checking bench for fir_decim_avg: directed plan steps plus random traffic against a queue-based model.
module tb_fir_decim_avg;

    localparam int IN_W  = 10;
    localparam int DECIM = 4;
`ifdef FIR_DECIM_ROUND_EN
    localparam int RND   = DECIM / 2;
    localparam int EXP_T2 = 3;
`else
    localparam int RND   = 0;
    localparam int EXP_T2 = 2;
`endif

    logic            Clk;
    logic            Rst;
    logic [IN_W-1:0] Y_in;
    logic            Y_valid;
    logic [IN_W-1:0] Avg_out;
    logic            Avg_valid;
    logic            Avg_ready;
    logic            Ovf;

    int checks = 0;
    int errors = 0;

    int q[$];
    int blk_sum = 0;
    int blk_cnt = 0;
    int shown   = 0;
    int ovf_m   = 0;

    fir_decim_avg #(.IN_W(IN_W), .LOG2_DECIM(2)) dut (
        .Clk(Clk), .Rst(Rst), .Y_in(Y_in), .Y_valid(Y_valid),
        .Avg_out(Avg_out), .Avg_valid(Avg_valid), .Avg_ready(Avg_ready), .Ovf(Ovf)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive at negedge, update the model at posedge, check at next negedge.
    task automatic step(input bit v, input int y, input bit r);
        int res;
        Y_valid   = v;
        Y_in      = y[IN_W-1:0];
        Avg_ready = r;
        @(posedge Clk);
        if (q.size() > 0 && r) void'(q.pop_front());
        if (v) begin
            blk_sum += y;
            blk_cnt++;
            if (blk_cnt == DECIM) begin
                res = (blk_sum + RND) / DECIM;
                if (q.size() < 2) q.push_back(res);
                else ovf_m = 1;
                blk_sum = 0;
                blk_cnt = 0;
            end
        end
        if (q.size() > 0) shown = q[0];
        @(negedge Clk);
        chk("avg_valid", {31'd0, Avg_valid}, (q.size() > 0) ? 32'd1 : 32'd0);
        chk("avg_out", {22'd0, Avg_out}, shown);
        chk("ovf", {31'd0, Ovf}, ovf_m);
    endtask

    task automatic do_reset();
        Rst       = 1'b0;
        Y_valid   = 1'b0;
        Avg_ready = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        q.delete();
        blk_sum = 0;
        blk_cnt = 0;
        shown   = 0;
        ovf_m   = 0;
        chk("rst_valid", {31'd0, Avg_valid}, 32'd0);
        chk("rst_out", {22'd0, Avg_out}, 32'd0);
        chk("rst_ovf", {31'd0, Ovf}, 32'd0);
        Rst = 1'b1;
    endtask

    initial begin
        Rst = 1'b1; Y_in = '0; Y_valid = 1'b0; Avg_ready = 1'b0;
        #2;
        // Test 1: reset then idle
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 0, 1'b0);

        // Test 2: 1,2,3,4 -> single result
        for (int i = 1; i <= 4; i++) step(1'b1, i, 1'b1);
        chk("t2_valid", {31'd0, Avg_valid}, 32'd1);
        chk("t2_out", {22'd0, Avg_out}, EXP_T2);
        step(1'b0, 0, 1'b1);
        chk("t2_one_cycle", {31'd0, Avg_valid}, 32'd0);

        // Test 3: samples with gaps
        step(1'b1, 4, 1'b1);  step(1'b0, 0, 1'b1);
        step(1'b1, 8, 1'b1);  step(1'b0, 0, 1'b1); step(1'b0, 0, 1'b1);
        step(1'b1, 12, 1'b1); step(1'b1, 16, 1'b1);
        chk("t3_out", {22'd0, Avg_out}, 32'd10);
        step(1'b0, 0, 1'b1);

        // Test 4: overflow with stalled consumer
        for (int i = 0; i < 12; i++) step(1'b1, 1023, 1'b0);
        chk("t4_ovf", {31'd0, Ovf}, 32'd1);
        chk("t4_head", {22'd0, Avg_out}, 32'd1023);
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1);
        chk("t4_drained", {31'd0, Avg_valid}, 32'd0);
        chk("t4_ovf_sticky", {31'd0, Ovf}, 32'd1);

        // Test 5: push and pop on the same edge while full
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 5, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 6, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 7, 1'b0);
        step(1'b1, 7, 1'b1);
        chk("t5_head6", {22'd0, Avg_out}, 32'd6);
        chk("t5_no_ovf", {31'd0, Ovf}, 32'd0);
        step(1'b0, 0, 1'b1);
        chk("t5_head7", {22'd0, Avg_out}, 32'd7);
        step(1'b0, 0, 1'b1);

        // Test 6: reset mid-block discards partial sum
        step(1'b1, 100, 1'b1); step(1'b1, 100, 1'b1);
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8, 1'b1);
        chk("t6_out", {22'd0, Avg_out}, 32'd8);
        step(1'b0, 0, 1'b1);

        // Random traffic, including boundary sample values and stalls
        for (int i = 0; i < 400; i++) begin
            int y;
            int sel;
            sel = $urandom_range(0, 3);
            if (sel == 0)      y = 0;
            else if (sel == 1) y = 1023;
            else               y = $urandom_range(0, 1023);
            if (i == 200) do_reset();
            step($urandom_range(0, 3) != 0, y, (i % 64) < 40 ? ($urandom_range(0, 3) != 0) : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_decim_avg.md
Name: fir_decim_avg

Overview:
- Downstream stage of the 3rd-order FIR filter.
- Consumes the filter's 10-bit unsigned output stream, averages each block of 2^LOG2_DECIM valid samples, and buffers the averages in a 2-entry output queue with a valid/ready handshake.
- Reduces sample rate and noise ahead of the output consumer, and flags lost results.

Parameters:
- IN_W, 10, width of the FIR output sample and of the averaged output.
- LOG2_DECIM, 2, log2 of the decimation factor. DECIM = 2^LOG2_DECIM. Legal range 0..4.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Rst  input  1  reset, asynchronous, active-low; one clock, no other clock domain.
- Y_in  input  IN_W  unsigned FIR output sample.
- Y_valid  input  1  Y_in qualifier; a sample is consumed on every rising edge where Y_valid=1.
- Avg_out  output  IN_W  head-of-queue averaged sample.
- Avg_valid  output  1  queue not empty.
- Avg_ready  input  1  consumer accepts Avg_out when Avg_valid&Avg_ready.
- Ovf  output  1  sticky: a result was dropped because the queue was full.

Behaviour:
- Reset (Rst=0, asynchronous): acc=0, cnt=0, queue EMPTY, Avg_out=0, Avg_valid=0, Ovf=0. Any partial block is discarded.
- Accumulator: acc is IN_W+LOG2_DECIM bits wide and cannot overflow. cnt is a LOG2_DECIM-bit counter.
- Y_valid=1 and cnt != DECIM-1: acc <= acc+Y_in; cnt <= cnt+1.
- Y_valid=1 and cnt == DECIM-1:
  - result = (acc+Y_in) >> LOG2_DECIM, truncating.
  - Push result into the queue.
  - acc <= 0; cnt <= 0.
- Y_valid=0: acc and cnt hold. Gaps of any length are allowed.
- LOG2_DECIM=0: every valid sample is pushed unchanged.
- Latency: result enters the queue on the edge that captures the DECIM-th sample. If the queue was empty, Avg_valid=1 in the following cycle.
- Queue states:
  - EMPTY: no push → EMPTY; push → ONE.
  - ONE: push and no pop → FULL; pop and no push → EMPTY; push and pop → ONE (new result becomes head).
  - FULL: pop and no push → ONE; push and pop → FULL, no drop; push and no pop → FULL, new result dropped, Ovf <= 1.
- Avg_out always shows the head entry; it is stable while Avg_valid=1 and Avg_ready=0. In EMPTY, Avg_out holds its last value (0 after reset).
- Ovf stays 1 until the next reset. Dropping a result never corrupts the queued entries.
- Pop rule: pop occurs only when Avg_valid=1 and Avg_ready=1. Avg_ready while EMPTY has no effect.

Optional Feature:
- Macro: FIR_DECIM_ROUND_EN.
- Defined: result = (acc + Y_in + 2^(LOG2_DECIM-1)) >> LOG2_DECIM, i.e. round half up. With LOG2_DECIM=0 no rounding term is added. The maximum result stays 2^IN_W-1, so no saturation logic is needed.
- Undefined: truncating shift only; no rounding adder is synthesised.

Test Plan:
1. Hold Rst=0 for 2 cycles, then release → Avg_valid=0, Avg_out=0, Ovf=0. Idle for 10 cycles with Y_valid=0 → still no output.
2. Avg_ready=1; send Y_in=1,2,3,4 on consecutive cycles → Avg_valid=1 for exactly one cycle, the cycle after sample 4, with Avg_out=2. With FIR_DECIM_ROUND_EN, Avg_out=3.
3. Send 4, gap, 8, gap, gap, 12, 16 with Y_valid gaps → Avg_out=10, one result only.
4. Avg_ready=0; send 12 samples of 1023 → queue FULL after 8 samples (1023,1023); third result dropped, Ovf=1. Then Avg_ready=1 → exactly two outputs of 1023, then Avg_valid=0; Ovf remains 1.
5. Fill the queue (results 5,6), then complete a third block (average 7) on the same edge that pops 5 → no drop, Ovf=0, subsequent outputs 6 then 7.
6. Send 2 samples of 100, pulse Rst low mid-block, then send 4 samples of 8 → single output 8; the partial block is discarded.
